// File: rtl/aud_play_sequencer.sv
// Playback sequencer between sample memory and the I2S serializer. It presents one sample per LR frame.
// Defining AUD_SEQ_UNDERRUN_CNT_EN adds a saturating underrun counter on o_underrun_cnt.
module aud_play_sequencer #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
) (
    input  logic              i_bclk,
    input  logic              i_rst_n,
    input  logic              i_daclrck,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    input  logic              i_loop,
    input  logic [ADDR_W-1:0] i_end_addr,
    output logic              o_rd_req,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic              i_rd_valid,
    input  logic [DATA_W-1:0] i_rd_data,
    output logic              o_player_en,
    output logic [DATA_W-1:0] o_dac_data,
    output logic [2:0]        o_state,
    output logic              o_done,
    output logic              o_underrun,
    output logic [7:0]        o_underrun_cnt
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        WAIT_LR = 3'd2,
        PAUSE   = 3'd3,
        DRAIN   = 3'd4
    } state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] addr, addr_nx;
    logic [ADDR_W-1:0] end_addr, end_nx;
    logic [DATA_W-1:0] buffer, buffer_nx;
    logic [DATA_W-1:0] dac_data, dac_nx;
    logic              buf_full, full_nx;
    logic              pend, pend_nx;
    logic              player_en, en_nx;
    logic              done, done_nx;
    logic              underrun, underrun_nx;
    logic              lrck_prev;
    logic              fe;
    logic              running;
    logic              pause_now;
    logic              start_ok;

    assign fe        = lrck_prev & ~i_daclrck;
    assign running   = (state == FETCH) || (state == WAIT_LR);
    assign pause_now = running && (pend || i_pause);
    assign start_ok  = i_start && !i_pause;

    // A read left open by a pause stays requested until its data lands in the buffer
    assign o_rd_req       = (state == FETCH) || ((state == PAUSE) && !buf_full);
    assign o_rd_addr      = addr;
    assign o_player_en    = player_en;
    assign o_dac_data     = dac_data;
    assign o_state        = state;
    assign o_done         = done;
    assign o_underrun     = underrun;

    always_comb begin
        state_nx    = state;
        addr_nx     = addr;
        end_nx      = end_addr;
        buffer_nx   = buffer;
        full_nx     = buf_full;
        pend_nx     = pend;
        en_nx       = player_en;
        dac_nx      = dac_data;
        done_nx     = 1'b0;
        underrun_nx = 1'b0;
        if (i_stop) begin
            state_nx = IDLE;
            addr_nx  = '0;
            full_nx  = 1'b0;
            pend_nx  = 1'b0;
            en_nx    = 1'b0;
            dac_nx   = '0;
        end else begin
            if (running && i_pause) begin
                pend_nx = 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        end_nx   = i_end_addr;
                        addr_nx  = '0;
                        full_nx  = 1'b0;
                        state_nx = FETCH;
                    end
                end
                FETCH: begin
                    if (i_rd_valid) begin
                        buffer_nx = i_rd_data;
                        full_nx   = 1'b1;
                        state_nx  = WAIT_LR;
                    end
                    // Data that arrives on the frame edge itself still counts as late
                    if (fe) begin
                        if (pause_now) begin
                            en_nx    = 1'b0;
                            pend_nx  = 1'b0;
                            state_nx = PAUSE;
                        end else begin
                            underrun_nx = 1'b1;
                        end
                    end
                end
                WAIT_LR: begin
                    if (fe) begin
                        if (pause_now) begin
                            en_nx    = 1'b0;
                            pend_nx  = 1'b0;
                            state_nx = PAUSE;
                        end else begin
                            dac_nx  = buffer;
                            en_nx   = 1'b1;
                            full_nx = 1'b0;
                            if ((addr == end_addr) && !i_loop) begin
                                state_nx = DRAIN;
                            end else begin
                                addr_nx  = (addr == end_addr) ? '0 : addr + ADDR_W'(1);
                                state_nx = FETCH;
                            end
                        end
                    end
                end
                PAUSE: begin
                    if (i_rd_valid && !buf_full) begin
                        buffer_nx = i_rd_data;
                        full_nx   = 1'b1;
                    end
                    if (start_ok) begin
                        state_nx = full_nx ? WAIT_LR : FETCH;
                    end
                end
                DRAIN: begin
                    if (fe) begin
                        en_nx    = 1'b0;
                        dac_nx   = '0;
                        done_nx  = 1'b1;
                        state_nx = IDLE;
                    end
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_bclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            addr      <= '0;
            end_addr  <= '0;
            buffer    <= '0;
            buf_full  <= 1'b0;
            pend      <= 1'b0;
            player_en <= 1'b0;
            dac_data  <= '0;
            done      <= 1'b0;
            underrun  <= 1'b0;
            lrck_prev <= 1'b1;
        end else begin
            state     <= state_nx;
            addr      <= addr_nx;
            end_addr  <= end_nx;
            buffer    <= buffer_nx;
            buf_full  <= full_nx;
            pend      <= pend_nx;
            player_en <= en_nx;
            dac_data  <= dac_nx;
            done      <= done_nx;
            underrun  <= underrun_nx;
            lrck_prev <= i_daclrck;
        end
    end

`ifdef AUD_SEQ_UNDERRUN_CNT_EN
    logic [7:0] underrun_cnt;

    always_ff @(posedge i_bclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            underrun_cnt <= '0;
        end else if (!i_stop && (state == IDLE) && start_ok) begin
            underrun_cnt <= '0;
        end else if (underrun_nx && (underrun_cnt != 8'hFF)) begin
            underrun_cnt <= underrun_cnt + 8'd1;
        end
    end

    assign o_underrun_cnt = underrun_cnt;
`else
    assign o_underrun_cnt = 8'd0;
`endif

endmodule
